// File: rtl/parallel_elementwise_mac_pkg.sv
// Shared definitions for the parallel elementwise multiply / dot-product block:
// FSM encoding, operating-mode constants and accumulator sizing.
package parallel_elementwise_mac_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_e;

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_MAC = 1'b1;

  // The sum of len products of n-bit operands needs clog2(len) guard bits above 2n.
  function automatic int calc_acc_w(input int n, input int len);
    return (len <= 1) ? 2 * n : 2 * n + $clog2(len);
  endfunction

endpackage

// File: rtl/parallel_elementwise_mac_if.sv
// Operand/result handshake bundle for parallel_elementwise_mac.
// The master side offers operands and consumes results; the slave side is the block.
interface parallel_elementwise_mac_if
  import parallel_elementwise_mac_pkg::*;
#(
  parameter int N   = 8,
  parameter int LEN = 8,
  parameter int CH  = 2
);
  localparam int ACC_W = calc_acc_w(N, LEN);

  logic                      in_valid;
  logic                      in_ready;
  logic                      mode;
  logic [CH*LEN*N-1:0]       a_flat;
  logic [CH*LEN*N-1:0]       b_flat;
  logic                      out_valid;
  logic                      out_ready;
  logic [CH*LEN*2*N-1:0]     result_flat;
  logic [CH*ACC_W-1:0]       dot_flat;
  logic                      busy;

  modport master (
    output in_valid, mode, a_flat, b_flat, out_ready,
    input  in_ready, out_valid, result_flat, dot_flat, busy
  );

  modport slave (
    input  in_valid, mode, a_flat, b_flat, out_ready,
    output in_ready, out_valid, result_flat, dot_flat, busy
  );

endinterface

// File: rtl/parallel_elementwise_mac_lane.sv
// One channel's multiplier and dot-product accumulator. Element selection and
// sequencing live in the parent; this lane only multiplies and accumulates.
module elementwise_mac_lane
  import parallel_elementwise_mac_pkg::*;
#(
  parameter int N     = 8,
  parameter int ACC_W = 2 * N
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     a_i,
  input  logic [N-1:0]     b_i,
  input  logic             mode_i,
  input  logic             clear_i,
  input  logic             en_i,
  output logic [2*N-1:0]   prod_o,
  output logic [ACC_W-1:0] acc_o
);

  logic [ACC_W-1:0] acc_q, acc_d;

  // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    prod_o = {{N{1'b0}}, a_i} * {{N{1'b0}}, b_i};
    acc_d  = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (en_i && (mode_i == MODE_MAC)) begin
      acc_d = acc_q + ACC_W'(prod_o);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/parallel_elementwise_mac.sv
// Latches CH channels of LEN-element vectors, multiplies them one element per
// cycle per channel, and optionally accumulates a per-channel dot product.
module parallel_elementwise_mac
  import parallel_elementwise_mac_pkg::*;
#(
  parameter int N   = 8,
  parameter int LEN = 8,
  parameter int CH  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  parallel_elementwise_mac_if.slave bus
);

  localparam int ACC_W = calc_acc_w(N, LEN);
  localparam int IDX_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LEN - 1);

  // Packed so that element i of channel c sits at the flat-bus offset (c*LEN+i)*width.
  typedef logic [CH-1:0][LEN-1:0][N-1:0]   opnd_t;
  typedef logic [CH-1:0][LEN-1:0][2*N-1:0] res_t;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             mode_q, mode_d;
  opnd_t            a_q, a_d, b_q, b_d;
  res_t             result_q, result_d;

  logic             accept;
  logic             lane_en;
  logic [N-1:0]     a_sel [CH];
  logic [N-1:0]     b_sel [CH];
  logic [2*N-1:0]   prod  [CH];
  logic [ACC_W-1:0] acc   [CH];
  logic [CH*ACC_W-1:0] dot;

  assign accept  = bus.in_valid && (state_q == IDLE);
  assign lane_en = (state_q == COMPUTE);

  always_comb begin
    for (int c = 0; c < CH; c++) begin
      a_sel[c] = a_q[c][idx_q];
      b_sel[c] = b_q[c][idx_q];
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    mode_d   = mode_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d      = bus.a_flat;
          b_d      = bus.b_flat;
          mode_d   = bus.mode;
          result_d = '0;
          idx_d    = '0;
          state_d  = COMPUTE;
        end
      end
      COMPUTE: begin
        for (int c = 0; c < CH; c++) begin
          result_d[c][idx_q] = prod[c];
        end
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: result and operand registers are reset because a reset must leave zeroed outputs visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      mode_q   <= MODE_MUL;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      mode_q   <= mode_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_lane
    elementwise_mac_lane #(
      .N     (N),
      .ACC_W (ACC_W)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .a_i     (a_sel[c]),
      .b_i     (b_sel[c]),
      .mode_i  (mode_q),
      .clear_i (accept),
      .en_i    (lane_en),
      .prod_o  (prod[c]),
      .acc_o   (acc[c])
    );
  end

  always_comb begin
    dot = '0;
    for (int c = 0; c < CH; c++) begin
      dot[c*ACC_W +: ACC_W] = acc[c];
    end
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.out_valid   = (state_q == DONE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.result_flat = result_q;
  assign bus.dot_flat    = dot;

endmodule

// File: tb/tb_parallel_elementwise_mac.sv
// Scoreboard bench for parallel_elementwise_mac at N=8, LEN=4, CH=2: expected
// results are queued at accept and compared when the block hands results over.
module tb_parallel_elementwise_mac;

  localparam int N     = 8;
  localparam int LEN   = 4;
  localparam int CH    = 2;
  localparam int ACC_W = 18;
  localparam int OW    = CH * LEN * N;
  localparam int RW    = CH * LEN * 2 * N;
  localparam int DW    = CH * ACC_W;

  typedef struct packed {
    logic [RW-1:0] res;
    logic [DW-1:0] dot;
  } exp_t;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   chk_cnt;
  exp_t sb[$];

  parallel_elementwise_mac_if #(.N(N), .LEN(LEN), .CH(CH)) bus ();

  parallel_elementwise_mac #(.N(N), .LEN(LEN), .CH(CH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic exp_t model(input logic [OW-1:0] a, input logic [OW-1:0] b, input logic m);
    exp_t r;
    r = '0;
    for (int c = 0; c < CH; c++) begin
      for (int i = 0; i < LEN; i++) begin
        logic [15:0] p;
        p = 16'(a[(c*LEN+i)*N +: N]) * 16'(b[(c*LEN+i)*N +: N]);
        r.res[(c*LEN+i)*16 +: 16] = p;
        if (m) r.dot[c*ACC_W +: ACC_W] = r.dot[c*ACC_W +: ACC_W] + ACC_W'(p);
      end
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers an operand set from IDLE and leaves in_valid asserted; the caller drops it.
  task automatic accept_op(input logic [OW-1:0] a, input logic [OW-1:0] b, input logic m, input bit track);
    check("pre_accept_in_ready", bus.in_ready, 1);
    bus.a_flat   = a;
    bus.b_flat   = b;
    bus.mode     = m;
    bus.in_valid = 1'b1;
    step();
    check("accept_busy", bus.busy, 1);
    check("accept_in_ready", bus.in_ready, 0);
    if (track) sb.push_back(model(a, b, m));
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!bus.out_valid && cyc < 20) begin
      step();
      cyc++;
    end
    check("out_valid_rise", bus.out_valid, 1);
  endtask

  task automatic consume(output exp_t got);
    exp_t e;
    check("sb_nonempty", sb.size() != 0, 1);
    e = (sb.size() != 0) ? sb.pop_front() : '0;
    check("result", bus.result_flat, e.res);
    check("dot", bus.dot_flat, e.dot);
    got.res = bus.result_flat;
    got.dot = bus.dot_flat;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("consumed_out_valid", bus.out_valid, 0);
    check("consumed_in_ready", bus.in_ready, 1);
  endtask

  localparam logic [OW-1:0] A0 = 64'h010A00FF_04030201;
  localparam logic [OW-1:0] B0 = 64'h010A09FF_08070605;
  localparam logic [RW-1:0] R0 = 128'h0001_0064_0000_FE01_0020_0015_000C_0005;

  initial begin
    int   cyc;
    bit   seen;
    exp_t got;
    logic [OW-1:0] ones;
    logic [OW-1:0] ra, rb;
    ones     = '1;
    pass_cnt = 0;
    chk_cnt  = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.mode      = 1'b0;
    bus.a_flat    = '0;
    bus.b_flat    = '0;
    repeat (3) step();

    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_result", bus.result_flat, 0);
    check("rst_dot", bus.dot_flat, 0);
    rst = 1'b0;
    step();

    // Mode 0: products only, dot stays zero, LEN cycles of latency.
    accept_op(A0, B0, 1'b0, 1);
    bus.in_valid = 1'b0;
    wait_done(cyc);
    check("latency_mul", cyc, LEN);
    consume(got);
    check("mul_products_literal", got.res, R0);
    check("mul_dot_zero", got.dot, 0);

    // Mode 1 on the same operands.
    accept_op(A0, B0, 1'b1, 1);
    bus.in_valid = 1'b0;
    wait_done(cyc);
    check("latency_mac", cyc, LEN);
    consume(got);
    check("mac_products_literal", got.res, R0);
    check("mac_dot_ch0", got.dot[17:0], 70);
    check("mac_dot_ch1", got.dot[35:18], 65126);

    // Worst-case operands must not wrap the 18-bit accumulator.
    accept_op(ones, ones, 1'b1, 1);
    bus.in_valid = 1'b0;
    wait_done(cyc);
    consume(got);
    check("max_dot_ch0", got.dot[17:0], 260100);
    check("max_dot_ch1", got.dot[35:18], 260100);

    // Operand inputs change one cycle after accept.
    accept_op(A0, B0, 1'b1, 1);
    bus.in_valid = 1'b0;
    step();
    bus.a_flat = ones;
    wait_done(cyc);
    consume(got);

    // Backpressure with in_valid held high through DONE.
    accept_op(A0, B0, 1'b1, 1);
    wait_done(cyc);
    bus.a_flat = ones;
    bus.b_flat = B0;
    bus.mode   = 1'b1;
    for (int k = 0; k < 10; k++) begin
      check("hold_out_valid", bus.out_valid, 1);
      check("hold_in_ready", bus.in_ready, 0);
      check("hold_result", bus.result_flat, sb[0].res);
      check("hold_dot", bus.dot_flat, sb[0].dot);
      step();
    end
    consume(got);
    check("no_accept_on_consume", bus.busy, 0);
    accept_op(ones, B0, 1'b1, 1);
    bus.in_valid = 1'b0;
    wait_done(cyc);
    consume(got);

    // Reset during the second COMPUTE cycle discards the operation.
    accept_op(A0, B0, 1'b1, 0);
    bus.in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_in_ready", bus.in_ready, 1);
    check("midrst_busy", bus.busy, 0);
    check("midrst_result", bus.result_flat, 0);
    check("midrst_dot", bus.dot_flat, 0);
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (bus.out_valid) seen = 1'b1;
      step();
    end
    check("midrst_no_out_valid", seen, 0);
    accept_op(B0, A0, 1'b1, 1);
    bus.in_valid = 1'b0;
    wait_done(cyc);
    check("latency_after_rst", cyc, LEN);
    consume(got);

    // A few random operand sets in both modes.
    for (int t = 0; t < 4; t++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      accept_op(ra, rb, 1'(t), 1);
      bus.in_valid = 1'b0;
      wait_done(cyc);
      consume(got);
    end

    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
